// File: rtl/ram_pkg.sv
// ram_pkg: definitions shared by the single-port clearable RAM.
//   ram_state_t  - controller state (CLEAR sweep / READY for accesses)
//   DATA_W_DEF   - default word width in bits
//   ADDR_W_DEF   - default address width in bits
//   byte_lanes() - number of byte lanes (and byte-enable bits) in a word
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_t;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 8;

  function automatic int byte_lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ram_clr_ctrl.sv
// ram_clr_ctrl: clear sequencer for ram_sp_clr. After reset, or after a clr
// pulse, it walks every word address once and asks the RAM to zero it.
//
// state | meaning
// CLEAR | sweeping: zero mem[cnt] each cycle, busy high
// READY | sweep done, user accesses allowed
//
// Ports:
//   clk, rst    - clock, asynchronous active-high reset (forces CLEAR, cnt 0)
//   clr         - restart the sweep from address 0
//   busy        - high while the sweep is running
//   sweep_addr  - word address being zeroed this cycle
//   sweep_we    - zero the word at sweep_addr on this edge
module ram_clr_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              sweep_we
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  ram_state_t        state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        if (clr) begin
          cnt_nxt = '0;
        end else if (cnt == LAST) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      READY: begin
        if (clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy       = (state == CLEAR);
  assign sweep_we   = (state == CLEAR);
  assign sweep_addr = cnt;

endmodule

// File: rtl/ram_sp_clr.sv
// ram_sp_clr: single-port synchronous RAM with byte-enable writes, registered
// read data with a valid flag, address range error flag and an optional
// clear sweep that zeroes every word after reset or on a clr pulse.
//
// Build option: define RAM_SP_CLR_EN to build the clear sequencer. Without it
// busy is tied low, clr is ignored and memory powers up uninitialised.
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (outputs only)
//   cen, wen  - access request; wen=1 write, wen=0 read
//   s_addr    - word address
//   s_din     - write data
//   s_be      - byte enables, bit i covers s_din[8i+7:8i]
//   clr       - pulse to restart the clear sweep
//   s_dout    - read data, zero unless s_valid
//   s_valid   - previous cycle was an accepted read
//   s_err     - previous cycle's access was out of range
//   busy      - clear sweep running, accesses dropped
module ram_sp_clr
  import ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cen,
  input  logic                wen,
  input  logic [ADDR_W-1:0]   s_addr,
  input  logic [DATA_W-1:0]   s_din,
  input  logic [DATA_W/8-1:0] s_be,
  input  logic                clr,
  output logic [DATA_W-1:0]   s_dout,
  output logic                s_valid,
  output logic                s_err,
  output logic                busy
);

  localparam int LANES = byte_lanes(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;
  logic              clr_hit;

`ifdef RAM_SP_CLR_EN
  ram_clr_ctrl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .busy       (busy),
    .sweep_addr (sweep_addr),
    .sweep_we   (sweep_we)
  );
  // A clr seen in READY pre-empts any access presented with it.
  assign clr_hit = clr;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign busy       = 1'b0;
  assign sweep_we   = 1'b0;
  assign sweep_addr = '0;
  assign clr_hit    = 1'b0;
`endif

  logic in_range, acc, wr, rd;

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  assign in_range = ({1'b0, s_addr} < (ADDR_W + 1)'(DEPTH));
  assign acc      = cen & ~busy & ~clr_hit;
  assign wr       = acc & wen & in_range;
  assign rd       = acc & ~wen & in_range;

  // Contents are deliberately not reset; only the sweep zeroes them.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= '0;
    end else if (wr) begin
      for (int i = 0; i < LANES; i++) begin
        if (s_be[i]) mem[s_addr][8*i +: 8] <= s_din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_dout  <= '0;
      s_valid <= 1'b0;
      s_err   <= 1'b0;
    end else begin
      s_dout  <= '0;
      s_valid <= 1'b0;
      s_err   <= acc & ~in_range;
      if (rd) begin
        s_dout  <= mem[s_addr];
        s_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_sp_clr.sv
module tb_ram_sp_clr;

  localparam int DW = 64;
  localparam int AW = 8;
  localparam int NB = DW / 8;

`ifdef RAM_SP_CLR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cen, wen, clr;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_din;
  logic [NB-1:0] s_be;

  logic [DW-1:0] a_dout, b_dout;
  logic          a_valid, a_err, a_busy;
  logic          b_valid, b_err, b_busy;

  always #5 clk = ~clk;

  // Two depths share one stimulus stream: 256 (full address space) and 200.
  ram_sp_clr #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256)) dut_a (
    .clk(clk), .rst(rst), .cen(cen), .wen(wen), .s_addr(s_addr),
    .s_din(s_din), .s_be(s_be), .clr(clr),
    .s_dout(a_dout), .s_valid(a_valid), .s_err(a_err), .busy(a_busy)
  );

  ram_sp_clr #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(200)) dut_b (
    .clk(clk), .rst(rst), .cen(cen), .wen(wen), .s_addr(s_addr),
    .s_din(s_din), .s_be(s_be), .clr(clr),
    .s_dout(b_dout), .s_valid(b_valid), .s_err(b_err), .busy(b_busy)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: word arrays plus a count of sweep cycles remaining.
  int            dep  [2] = '{256, 200};
  logic [DW-1:0] mem  [2][256];
  int            left [2];
  logic [DW-1:0] e_dout  [2];
  logic          e_valid [2];
  logic          e_err   [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      left[k]    = CLR_EN ? dep[k] : 0;
      e_dout[k]  = '0;
      e_valid[k] = 1'b0;
      e_err[k]   = 1'b0;
      if (CLR_EN) for (int i = 0; i < 256; i++) mem[k][i] = '0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      e_dout[k]  = '0;
      e_valid[k] = 1'b0;
      e_err[k]   = 1'b0;
      if (left[k] > 0) begin
        left[k]--;
        if (CLR_EN && clr) left[k] = dep[k];
      end else if (CLR_EN && clr) begin
        left[k] = dep[k];
        for (int i = 0; i < 256; i++) mem[k][i] = '0;
      end else if (cen) begin
        if (int'(s_addr) >= dep[k]) e_err[k] = 1'b1;
        else if (wen) begin
          for (int b = 0; b < NB; b++)
            if (s_be[b]) mem[k][s_addr][8*b +: 8] = s_din[8*b +: 8];
        end else begin
          e_dout[k]  = mem[k][s_addr];
          e_valid[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input string tag);
    logic [DW+2:0] obs, exp;
    obs = {a_dout, a_valid, a_err, a_busy};
    exp = {e_dout[0], e_valid[0], e_err[0], left[0] > 0};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[d256] obs=%h exp=%h", tag, obs, exp);
    end
    obs = {b_dout, b_valid, b_err, b_busy};
    exp = {e_dout[1], e_valid[1], e_err[1], left[1] > 0};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[d200] obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic c, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [NB-1:0] be,
                       input logic cl);
    cen = c; wen = w; s_addr = a; s_din = d; s_be = be; clr = cl;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
      step(tag);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) mem[k][i] = '0;
    rst = 1'b1;
    model_reset();
    #2;
    check("reset_async");
    @(posedge clk); #1;
    check("reset_hold");
    rst = 1'b0;

    // Random writes straight after reset: dropped while sweeping.
    for (int i = 0; i < 256; i++) begin
      drive($urandom_range(0, 1), 1'b1, AW'($urandom_range(0, 255)),
            {$urandom, $urandom}, NB'($urandom), 1'b0);
      step("sweep_drop");
    end

    // Give every word a known value.
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b1, AW'(i), '0, '1, 1'b0);
      step("init_wr");
    end

    drive(1'b1, 1'b0, 8'd0,   '0, '0, 1'b0); step("rd0");
    drive(1'b1, 1'b0, 8'd100, '0, '0, 1'b0); step("rd100");
    drive(1'b1, 1'b0, 8'd255, '0, '0, 1'b0); step("rd255");

    drive(1'b1, 1'b1, 8'd0,   64'h1111111111111111, 8'hFF, 1'b0); step("wr0");
    drive(1'b1, 1'b1, 8'd100, 64'h2222222222222222, 8'hFF, 1'b0); step("wr100");
    drive(1'b1, 1'b1, 8'd255, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0); step("wr255");
    drive(1'b1, 1'b0, 8'd0,   '0, '0, 1'b0); step("rb0");
    drive(1'b1, 1'b0, 8'd100, '0, '0, 1'b0); step("rb100");
    drive(1'b1, 1'b0, 8'd255, '0, '0, 1'b0); step("rb255");
    vectors++;
    assert (a_dout === 64'hFFFFFFFFFFFFFFFF) else begin
      miscompares++;
      $error("FAIL rb255_const obs=%h exp=%h", a_dout, 64'hFFFFFFFFFFFFFFFF);
    end

    drive(1'b1, 1'b1, 8'd234, 64'h1234567812345678, 8'hFF, 1'b0); step("be_full");
    drive(1'b1, 1'b1, 8'd234, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0); step("be_low");
    drive(1'b1, 1'b0, 8'd234, '0, '0, 1'b0); step("be_rd");
    vectors++;
    assert (a_dout === 64'h12345678AAAAAAAA) else begin
      miscompares++;
      $error("FAIL be_const obs=%h exp=%h", a_dout, 64'h12345678AAAAAAAA);
    end

    drive(1'b0, 1'b1, 8'd0, 64'h8888888888888888, 8'hFF, 1'b0); step("cen_off");
    drive(1'b1, 1'b0, 8'd0, '0, '0, 1'b0); step("cen_off_rd");

    drive(1'b1, 1'b0, 8'd210, '0, '0, 1'b0); step("oor_rd");
    drive(1'b1, 1'b1, 8'd210, 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b0); step("oor_wr");
    drive(1'b1, 1'b0, 8'd210, '0, '0, 1'b0); step("oor_rd2");
    idle(1, "oor_idle");

    drive(1'b1, 1'b1, 8'd7, 64'h0123456789ABCDEF, 8'hFF, 1'b0); step("raw_wr");
    drive(1'b1, 1'b0, 8'd7, '0, '0, 1'b0); step("raw_rd");

    // clr together with a write: clr wins, then a full sweep.
    drive(1'b1, 1'b1, 8'd5, 64'h5555555555555555, 8'hFF, 1'b1); step("clr_wr");
    idle(256, "clr_sweep");
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b0, AW'(i), '0, '0, 1'b0);
      step("clr_rd");
    end

    // Reset 50 cycles into a sweep.
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1); step("clr2");
    idle(50, "sweep50");
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_mid");
    @(posedge clk); #1;
    check("rst_mid_hold");
    rst = 1'b0;
    idle(256, "rst_sweep");

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1),
            AW'($urandom_range(0, 255)), {$urandom, $urandom},
            NB'($urandom), $urandom_range(0, 63) == 0);
      step("rand");
    end
    idle(2, "tail");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
